// File: rtl/mem_burst_tester.sv
// Self-checking DDR burst initiator: writes TEST_BURSTS bursts of a pass-seeded
// address pattern, reads them back, counts mismatches and completed passes.
module mem_burst_tester #(
    parameter int unsigned MEM_DATA_BITS = 64,
    parameter int unsigned ADDR_BITS     = 24,
    parameter logic [9:0]  BURST_LEN     = 10'd128,
    parameter logic [15:0] TEST_BURSTS   = 16'd64
) (
    input  logic                     rst,
    input  logic                     mem_clk,
    input  logic                     init_calib_complete,
    input  logic                     enable,
    output logic                     wr_burst_req,
    output logic [9:0]               wr_burst_len,
    output logic [ADDR_BITS-1:0]     wr_burst_addr,
    input  logic                     wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0] wr_burst_data,
    input  logic                     wr_burst_finish,
    output logic                     rd_burst_req,
    output logic [9:0]               rd_burst_len,
    output logic [ADDR_BITS-1:0]     rd_burst_addr,
    input  logic                     rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
    input  logic                     rd_burst_finish,
    output logic                     error,
    output logic [15:0]              error_cnt,
    output logic [7:0]               pass_cnt,
    output logic                     busy
);
    localparam int unsigned LANES = MEM_DATA_BITS / 16;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;
    logic [15:0]              burst_cnt_q, burst_cnt_d;
    logic [9:0]               wr_beat_q, wr_beat_d;
    logic [9:0]               rd_beat_q, rd_beat_d;
    logic                     wr_req_q, wr_req_d;
    logic                     rd_req_q, rd_req_d;
    logic [MEM_DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic                     error_q, error_d;
    logic [15:0]              error_cnt_q, error_cnt_d;
    logic [7:0]               pass_cnt_q, pass_cnt_d;
    logic                     busy_q, busy_d;
    logic                     mism;
    logic                     last_burst;
    logic [ADDR_BITS-1:0]     wr_a, rd_a;

    // Each 16-bit lane carries the low address bits scrambled by the pass count.
    function automatic logic [MEM_DATA_BITS-1:0] pattern(input logic [ADDR_BITS-1:0] a,
                                                         input logic [7:0] p);
        logic [15:0] lane;
        lane = 16'(a) ^ {p, p};
        return {LANES{lane}};
    endfunction

    assign wr_a       = addr_q + ADDR_BITS'(wr_beat_q);
    assign rd_a       = addr_q + ADDR_BITS'(rd_beat_q);
    assign last_burst = (burst_cnt_q == TEST_BURSTS - 16'd1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        burst_cnt_d = burst_cnt_q;
        wr_beat_d   = wr_beat_q;
        rd_beat_d   = rd_beat_q;
        wr_req_d    = wr_req_q;
        rd_req_d    = rd_req_q;
        wr_data_d   = wr_data_q;
        pass_cnt_d  = pass_cnt_q;
        mism        = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && init_calib_complete) begin
                    state_d     = WRITE;
                    addr_d      = '0;
                    burst_cnt_d = '0;
                    wr_beat_d   = '0;
                    wr_req_d    = 1'b1;
                end
            end
            WRITE: begin
                // Request dropped for one cycle after a finish, then re-raised.
                if (!wr_req_q) wr_req_d = 1'b1;
                if (wr_burst_data_req) begin
                    wr_data_d = pattern(wr_a, pass_cnt_q);
                    wr_beat_d = wr_beat_q + 10'd1;
                end
                if (wr_burst_finish && wr_req_q) begin
                    wr_req_d  = 1'b0;
                    wr_beat_d = '0;
                    if (last_burst) begin
                        addr_d      = '0;
                        burst_cnt_d = '0;
                        if (enable) begin
                            state_d   = READ;
                            rd_req_d  = 1'b1;
                            rd_beat_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        addr_d      = addr_q + ADDR_BITS'(BURST_LEN);
                        burst_cnt_d = burst_cnt_q + 16'd1;
                        if (!enable) state_d = IDLE;
                    end
                end
            end
            READ: begin
                if (!rd_req_q) rd_req_d = 1'b1;
                if (rd_burst_data_valid) begin
                    mism      = (rd_burst_data != pattern(rd_a, pass_cnt_q));
                    rd_beat_d = rd_beat_q + 10'd1;
                end
                if (rd_burst_finish && rd_req_q) begin
                    rd_req_d  = 1'b0;
                    rd_beat_d = '0;
                    if (last_burst) begin
                        addr_d      = '0;
                        burst_cnt_d = '0;
                        pass_cnt_d  = pass_cnt_q + 8'd1;
                        if (enable) begin
                            state_d   = WRITE;
                            wr_req_d  = 1'b1;
                            wr_beat_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        addr_d      = addr_q + ADDR_BITS'(BURST_LEN);
                        burst_cnt_d = burst_cnt_q + 16'd1;
                        if (!enable) state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Read data arriving while no read is outstanding is itself an error.
        if (rd_burst_data_valid && (state_q != READ)) mism = 1'b1;

        error_d     = error_q | mism;
        error_cnt_d = (mism && (error_cnt_q != 16'hFFFF)) ? error_cnt_q + 16'd1 : error_cnt_q;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            burst_cnt_q <= '0;
            wr_beat_q   <= '0;
            rd_beat_q   <= '0;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_data_q   <= '0;
            error_q     <= 1'b0;
            error_cnt_q <= '0;
            pass_cnt_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            burst_cnt_q <= burst_cnt_d;
            wr_beat_q   <= wr_beat_d;
            rd_beat_q   <= rd_beat_d;
            wr_req_q    <= wr_req_d;
            rd_req_q    <= rd_req_d;
            wr_data_q   <= wr_data_d;
            error_q     <= error_d;
            error_cnt_q <= error_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign wr_burst_req  = wr_req_q;
    assign wr_burst_len  = BURST_LEN;
    assign wr_burst_addr = addr_q;
    assign wr_burst_data = wr_data_q;
    assign rd_burst_req  = rd_req_q;
    assign rd_burst_len  = BURST_LEN;
    assign rd_burst_addr = addr_q;
    assign error         = error_q;
    assign error_cnt     = error_cnt_q;
    assign pass_cnt      = pass_cnt_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mem_burst_tester.sv
// Bench for mem_burst_tester: ideal controller with a small memory, scoreboard
// queues for requests, write beats and error counts, checked by monitors.
module tb_mem_burst_tester;
    logic        rst, mem_clk, calib, enable;
    logic        wr_burst_req, rd_burst_req, error, busy;
    logic [9:0]  wr_burst_len, rd_burst_len;
    logic [23:0] wr_burst_addr, rd_burst_addr;
    logic [63:0] wr_burst_data;
    logic [15:0] error_cnt;
    logic [7:0]  pass_cnt;

    logic        c_wr_dreq, c_wr_fin, c_rd_valid, c_rd_fin;
    logic [63:0] c_rd_data;
    logic        m_wr_fin, m_rd_fin, m_rd_valid;
    logic        wr_dreq_w, wr_fin_w, rd_valid_w, rd_fin_w;

    assign wr_dreq_w  = c_wr_dreq;
    assign wr_fin_w   = c_wr_fin | m_wr_fin;
    assign rd_valid_w = c_rd_valid | m_rd_valid;
    assign rd_fin_w   = c_rd_fin | m_rd_fin;

    int n_checks = 0;
    int n_err    = 0;
    int exp_err  = 0;

    logic [24:0] exp_req_q[$];
    logic [63:0] exp_wr_q[$];
    logic [15:0] exp_err_q[$];
    logic [63:0] mem [0:63];

    // Hand-computed lane values: address XOR {pass,pass}.
    logic [15:0] lanes_p0[8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                                 16'h0004, 16'h0005, 16'h0006, 16'h0007};
    logic [15:0] lanes_p1[8] = '{16'h0101, 16'h0100, 16'h0103, 16'h0102,
                                 16'h0105, 16'h0104, 16'h0107, 16'h0106};
    logic [15:0] lanes_p2[8] = '{16'h0202, 16'h0203, 16'h0200, 16'h0201,
                                 16'h0206, 16'h0207, 16'h0204, 16'h0205};
    bit          stall_seq[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    mem_burst_tester #(
        .MEM_DATA_BITS(64), .ADDR_BITS(24), .BURST_LEN(10'd4), .TEST_BURSTS(16'd2)
    ) dut (
        .rst(rst), .mem_clk(mem_clk), .init_calib_complete(calib), .enable(enable),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data_req(wr_dreq_w), .wr_burst_data(wr_burst_data), .wr_burst_finish(wr_fin_w),
        .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
        .rd_burst_data_valid(rd_valid_w), .rd_burst_data(c_rd_data), .rd_burst_finish(rd_fin_w),
        .error(error), .error_cnt(error_cnt), .pass_cnt(pass_cnt), .busy(busy)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic note_fail(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    task automatic push_pass(input int p, input int nbeats, input bit full);
        exp_req_q.push_back({1'b0, 24'd0});
        if (full) begin
            exp_req_q.push_back({1'b0, 24'd4});
            exp_req_q.push_back({1'b1, 24'd0});
            exp_req_q.push_back({1'b1, 24'd4});
        end
        for (int i = 0; i < nbeats; i++) begin
            if (p == 0)      exp_wr_q.push_back({4{lanes_p0[i]}});
            else if (p == 1) exp_wr_q.push_back({4{lanes_p1[i]}});
            else             exp_wr_q.push_back({4{lanes_p2[i]}});
        end
    endtask

    task automatic wait_pass(input logic [7:0] p);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge mem_clk); #3;
            if (pass_cnt == p) seen = 1'b1;
        end
        if (!seen) note_fail("timeout_pass_cnt");
    endtask

    // Ideal controller: serves one burst at a time from a 64-word memory.
    initial begin
        int a, beats, k, wbn, rbn;
        bit dreq, aborted;
        logic [63:0] prev;
        c_wr_dreq = 0; c_wr_fin = 0; c_rd_valid = 0; c_rd_fin = 0; c_rd_data = '0;
        wbn = 0; rbn = 0;
        forever begin
            @(posedge mem_clk); #1;
            if (rst) continue;
            aborted = 1'b0;
            if (wr_burst_req) begin
                a = int'(wr_burst_addr); beats = 0; k = 0; prev = wr_burst_data;
                while (beats < 4) begin
                    dreq = (wbn == 2 && k < 7) ? stall_seq[k] : 1'b1;
                    c_wr_dreq = dreq;
                    @(posedge mem_clk); #1;
                    if (rst) begin aborted = 1'b1; break; end
                    if (dreq) begin
                        mem[(a + beats) & 63] = wr_burst_data;
                        beats++;
                    end else begin
                        check64("stall_hold", wr_burst_data, prev);
                    end
                    prev = wr_burst_data;
                    k++;
                end
                c_wr_dreq = 1'b0;
                if (!aborted) begin
                    c_wr_fin = 1'b1; wbn++;
                    @(posedge mem_clk); #1;
                    c_wr_fin = 1'b0;
                end
            end else if (rd_burst_req) begin
                a = int'(rd_burst_addr);
                for (int i = 0; i < 4; i++) begin
                    c_rd_valid = 1'b1;
                    c_rd_data  = mem[(a + i) & 63];
                    if (rbn == 3 && i == 1) begin
                        c_rd_data = c_rd_data ^ 64'h0000_0000_0000_0100;
                        exp_err++;
                    end
                    exp_err_q.push_back(16'(exp_err));
                    @(posedge mem_clk); #1;
                    if (rst) begin aborted = 1'b1; break; end
                end
                c_rd_valid = 1'b0;
                if (!aborted) begin
                    c_rd_fin = 1'b1; rbn++;
                    @(posedge mem_clk); #1;
                    c_rd_fin = 1'b0;
                end
            end
        end
    end

    // Monitor: new beat appears on wr_burst_data after each requested edge.
    always @(posedge mem_clk) begin
        if (!rst && wr_dreq_w) begin
            #2;
            if (exp_wr_q.size() == 0) note_fail("wr_data_unexpected");
            else check64("wr_data", wr_burst_data, exp_wr_q.pop_front());
        end
    end

    // Monitor: error/error_cnt registered on the edge that samples a valid beat.
    always @(posedge mem_clk) begin
        logic [15:0] e;
        if (!rst && rd_valid_w) begin
            #2;
            if (exp_err_q.size() == 0) note_fail("rd_check_unexpected");
            else begin
                e = exp_err_q.pop_front();
                check64("error_cnt", 64'(error_cnt), 64'(e));
                check64("error_flag", 64'(error), 64'(e != 16'd0));
            end
        end
    end

    // Monitor: each new request must match the next expected {rd, addr}.
    logic pw = 1'b0, pr = 1'b0;
    always @(posedge mem_clk) begin
        #2;
        if (!rst) begin
            if (wr_burst_req && !pw) begin
                if (exp_req_q.size() == 0) note_fail("wr_req_unexpected");
                else check64("wr_req_addr", 64'({1'b0, wr_burst_addr}), 64'(exp_req_q.pop_front()));
            end
            if (rd_burst_req && !pr) begin
                if (exp_req_q.size() == 0) note_fail("rd_req_unexpected");
                else check64("rd_req_addr", 64'({1'b1, rd_burst_addr}), 64'(exp_req_q.pop_front()));
            end
        end
        pw = wr_burst_req;
        pr = rd_burst_req;
    end

    initial begin
        bit seen;
        rst = 1'b1; calib = 1'b0; enable = 1'b0;
        m_wr_fin = 1'b0; m_rd_fin = 1'b0; m_rd_valid = 1'b0;
        repeat (3) @(posedge mem_clk); #3;
        check64("rst_flags", 64'({wr_burst_req, rd_burst_req, error, busy, error_cnt, pass_cnt}), 64'd0);
        check64("rst_addr", 64'({wr_burst_addr, rd_burst_addr}), 64'd0);
        check64("rst_wdata", wr_burst_data, 64'd0);
        check64("burst_len", 64'({wr_burst_len, rd_burst_len}), 64'({10'd4, 10'd4}));

        rst = 1'b0; enable = 1'b1;
        repeat (3) @(posedge mem_clk); #3;
        check64("calib_gate", 64'({busy, wr_burst_req}), 64'd0);

        push_pass(0, 8, 1'b1);
        push_pass(1, 8, 1'b1);
        push_pass(2, 4, 1'b0);
        calib = 1'b1;

        wait_pass(8'd1);
        check64("pass0_clean", 64'({error, error_cnt, pass_cnt}), 64'({1'b0, 16'd0, 8'd1}));

        wait_pass(8'd2);
        enable = 1'b0;
        check64("pass1_error", 64'({error, error_cnt}), 64'({1'b1, 16'd1}));

        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge mem_clk); #3;
            if (wr_fin_w) seen = 1'b1;
        end
        if (!seen) note_fail("timeout_wr_finish");
        repeat (2) @(posedge mem_clk); #3;
        check64("idle_after_disable", 64'({busy, wr_burst_req, error}), 64'({1'b0, 1'b0, 1'b1}));
        repeat (5) @(posedge mem_clk); #3;
        check64("no_new_req", 64'({busy, wr_burst_req, rd_burst_req, pass_cnt}), 64'({3'b000, 8'd2}));

        push_pass(2, 8, 1'b1);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge mem_clk); #3;
            if (rd_burst_req) seen = 1'b1;
        end
        if (!seen) note_fail("timeout_rd_req");
        repeat (2) @(posedge mem_clk); #2;
        rst = 1'b1;
        #1;
        check64("rst_async", 64'({wr_burst_req, rd_burst_req, error, busy, error_cnt, pass_cnt}), 64'd0);

        repeat (2) @(posedge mem_clk);
        exp_req_q.delete(); exp_wr_q.delete(); exp_err_q.delete(); exp_err = 0;
        push_pass(0, 4, 1'b0);
        #3 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge mem_clk); #3;
            if (wr_burst_req) seen = 1'b1;
        end
        if (!seen) note_fail("timeout_restart_req");
        enable = 1'b0;
        check64("restart_state", 64'({pass_cnt, error}), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge mem_clk); #3;
            if (!busy) seen = 1'b1;
        end
        if (!seen) note_fail("timeout_idle");
        repeat (2) @(posedge mem_clk); #3;
        check64("queues_drained", 64'(exp_req_q.size() + exp_wr_q.size()), 64'd0);

        m_wr_fin = 1'b1; m_rd_fin = 1'b1;
        @(posedge mem_clk); #3;
        m_wr_fin = 1'b0; m_rd_fin = 1'b0;
        repeat (2) @(posedge mem_clk); #3;
        check64("stray_finish", 64'({busy, wr_burst_req, rd_burst_req, pass_cnt}), 64'd0);

        exp_err = 1;
        exp_err_q.push_back(16'd1);
        m_rd_valid = 1'b1;
        @(posedge mem_clk); #3;
        m_rd_valid = 1'b0;
        repeat (2) @(posedge mem_clk); #3;
        check64("stray_valid", 64'({error, error_cnt, busy}), 64'({1'b1, 16'd1, 1'b0}));
        check64("err_queue_drained", 64'(exp_err_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
